// File: rtl/mult_sequencer_if.sv
// Control/status bundle between the multiply sequencer, the
// shift-add datapath and the button/display logic.
interface mult_sequencer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic          start;
  logic          abort;
  logic          sign_a;
  logic          sign_b;
  logic          mplier_lsb;
  logic          mplier_zero;
  logic          load;
  logic          add_en;
  logic          shift_en;
  logic          negate;
  logic          busy;
  logic          done;
  logic          result_valid;
  logic [CW-1:0] iter_count;

  modport master (
    output start,
    output abort,
    output sign_a,
    output sign_b,
    output mplier_lsb,
    output mplier_zero,
    input  load,
    input  add_en,
    input  shift_en,
    input  negate,
    input  busy,
    input  done,
    input  result_valid,
    input  iter_count
  );

  modport slave (
    input  start,
    input  abort,
    input  sign_a,
    input  sign_b,
    input  mplier_lsb,
    input  mplier_zero,
    output load,
    output add_en,
    output shift_en,
    output negate,
    output busy,
    output done,
    output result_valid,
    output iter_count
  );
endinterface

// File: rtl/mult_sequencer.sv
// Cycle sequencer for the shift-add signed multiplier: issues
// load/add/shift/negate strobes, with optional early termination.
module mult_sequencer #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b1
) (
  input logic             clk,
  input logic             rst,
  mult_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MAXC = CW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    SHIFT,
    NEG,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          neg_r;
  logic          rv_r;
  logic [CW-1:0] cnt_r;
  logic          busy_s;
  logic          accept;
  logic          early;
  state_t        fin_st;

  assign busy_s = (state == LOAD) || (state == TEST) ||
                  (state == SHIFT) || (state == NEG);
  assign accept = bus.start &&
                  ((state == IDLE) || (state == DONE));
  assign early  = EARLY_TERM && bus.mplier_zero;
  assign fin_st = neg_r ? NEG : DONE;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.start ? LOAD : IDLE;
      DONE:    state_n = bus.start ? LOAD : IDLE;
      LOAD:    state_n = TEST;
      TEST:    state_n = early ? fin_st : SHIFT;
      SHIFT:   state_n = (cnt_r == LAST) ? fin_st : TEST;
      NEG:     state_n = DONE;
      default: state_n = IDLE;
    endcase
    // cancel beats every other transition, even the final one
    if (busy_s && bus.abort) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_r <= bus.sign_a ^ bus.sign_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_r <= 1'b0;
    end else if (accept) begin
      rv_r <= 1'b0;
    end else if (state_n == DONE) begin
      rv_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state == LOAD) begin
      cnt_r <= '0;
    end else if (state == SHIFT) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bus.load         = (state == LOAD);
  assign bus.shift_en     = (state == SHIFT);
  assign bus.negate       = (state == NEG);
  assign bus.done         = (state == DONE);
  assign bus.busy         = busy_s;
  assign bus.result_valid = rv_r;
  assign bus.iter_count   = cnt_r;
  // only strobe that follows the datapath within the cycle
  assign bus.add_en = (state == TEST) && !early &&
                      bus.mplier_lsb;

  a_strobe_onehot: assert property (
    @(posedge clk) disable iff (rst)
    $onehot0({bus.load, bus.add_en,
              bus.shift_en, bus.negate})
  );

  a_cnt_bound: assert property (
    @(posedge clk) cnt_r <= MAXC
  );
endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: two instances (full run and early
// termination) against a schedule-based reference model.
module tb_mult_sequencer;
  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  typedef struct packed {
    logic          load;
    logic          add;
    logic          shift;
    logic          neg;
    logic          busy;
    logic          done;
    logic          rv;
    logic [CW-1:0] ic;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st = 1'b0;
  logic         ab = 1'b0;
  logic         sa = 1'b0;
  logic         sb = 1'b0;
  logic [W-1:0] b_op = '0;
  logic [W-1:0] mreg [2];
  int           cyc = 0;
  int           t0 = 0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_sequencer_if #(.WIDTH(W)) bus0 ();
  mult_sequencer_if #(.WIDTH(W)) bus1 ();

  mult_sequencer #(.WIDTH(W), .EARLY_TERM(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  mult_sequencer #(.WIDTH(W), .EARLY_TERM(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  assign bus0.start  = st;
  assign bus0.abort  = ab;
  assign bus0.sign_a = sa;
  assign bus0.sign_b = sb;
  assign bus1.start  = st;
  assign bus1.abort  = ab;
  assign bus1.sign_a = sa;
  assign bus1.sign_b = sb;

  // behavioural multiplier register of each datapath
  always @(posedge clk) begin
    if (rst) mreg[0] <= '0;
    else if (bus0.load) mreg[0] <= b_op;
    else if (bus0.shift_en) mreg[0] <= mreg[0] >> 1;
    if (rst) mreg[1] <= '0;
    else if (bus1.load) mreg[1] <= b_op;
    else if (bus1.shift_en) mreg[1] <= mreg[1] >> 1;
  end

  assign bus0.mplier_lsb  = mreg[0][0];
  assign bus0.mplier_zero = (mreg[0] == '0);
  assign bus1.mplier_lsb  = mreg[1][0];
  assign bus1.mplier_zero = (mreg[1] == '0);

  exp_t act [2];
  assign act[0] = {bus0.load, bus0.add_en, bus0.shift_en,
                   bus0.negate, bus0.busy, bus0.done,
                   bus0.result_valid, bus0.iter_count};
  assign act[1] = {bus1.load, bus1.add_en, bus1.shift_en,
                   bus1.negate, bus1.busy, bus1.done,
                   bus1.result_valid, bus1.iter_count};

  // reference model state
  exp_t          cur [2];
  exp_t          sch [2][$];
  logic          rv [2];
  logic [CW-1:0] ic [2];
  bit            icx [2];
  bit            armed = 1'b0;

  // observations of the current directed run
  int r_load [2];
  int r_rvl [2];
  int r_add [2];
  int r_shift [2];
  int r_neg [2];
  int r_done [2];
  int r_ic [2];
  int r_busy10 [2];

  function automatic exp_t mk(
    input logic ld, input logic ad, input logic sh,
    input logic ng, input logic by, input logic dn,
    input logic v, input logic [CW-1:0] c);
    exp_t e;
    e = {ld, ad, sh, ng, by, dn, v, c};
    return e;
  endfunction

  // whole operation laid out cycle by cycle from the operands
  task automatic build(input int d, input logic [W-1:0] b,
                       input logic ng, input bit et);
    logic [W-1:0] m;
    int k;
    k = 0;
    sch[d].push_back(mk(1, 0, 0, 0, 1, 0, 0, ic[d]));
    for (int i = 0; i < W; i++) begin
      m = b >> i;
      if (et && m == '0) begin
        sch[d].push_back(mk(0, 0, 0, 0, 1, 0, 0, CW'(i)));
        break;
      end
      sch[d].push_back(mk(0, m[0], 0, 0, 1, 0, 0, CW'(i)));
      sch[d].push_back(mk(0, 0, 1, 0, 1, 0, 0, CW'(i)));
      k = i + 1;
    end
    if (ng) sch[d].push_back(mk(0, 0, 0, 1, 1, 0, 0, CW'(k)));
    sch[d].push_back(mk(0, 0, 0, 0, 0, 1, 1, CW'(k)));
  endtask

  task automatic step(input int d);
    if (rst) begin
      sch[d].delete();
      rv[d]  = 1'b0;
      ic[d]  = '0;
      icx[d] = 1'b0;
      cur[d] = mk(0, 0, 0, 0, 0, 0, 0, '0);
    end else if (sch[d].size() != 0) begin
      if (ab) begin
        sch[d].delete();
        icx[d] = 1'b1;
        rv[d]  = 1'b0;
        cur[d] = mk(0, 0, 0, 0, 0, 0, 0, ic[d]);
      end else begin
        cur[d] = sch[d].pop_front();
        if (!cur[d].load) begin
          icx[d] = 1'b0;
          ic[d]  = cur[d].ic;
        end
        rv[d] = cur[d].rv;
      end
    end else if (st) begin
      rv[d] = 1'b0;
      build(d, b_op, sa ^ sb, d == 1);
      cur[d] = sch[d].pop_front();
    end else begin
      cur[d] = mk(0, 0, 0, 0, 0, 0, rv[d], ic[d]);
    end
  endtask

  initial begin
    exp_t e;
    exp_t a;
    int   rel;
    forever begin
      @(negedge clk);
      rel = cyc - t0;
      for (int d = 0; d < 2; d++) begin
        if (armed) begin
          e = cur[d];
          a = act[d];
          if (icx[d]) begin
            e.ic = '0;
            a.ic = '0;
          end
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL cycle_cmp dut%0d cyc %0d: got %b expected %b",
                     d, cyc, act[d], cur[d]);
          end
          if (act[d].load && r_load[d] < 0) begin
            r_load[d] = rel;
            r_rvl[d]  = int'(act[d].rv);
          end
          if (act[d].add && rel >= 0 && rel < 32)
            r_add[d] |= (1 << rel);
          if (act[d].shift) r_shift[d]++;
          if (act[d].neg) r_neg[d] = rel;
          if (act[d].done) begin
            r_done[d] = rel;
            r_ic[d]   = int'(act[d].ic);
          end
          if (rel == 10) r_busy10[d] = int'(act[d].busy);
        end
        step(d);
      end
      if (rst) armed = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, want);
    end
  endtask

  task automatic clear_rec();
    for (int d = 0; d < 2; d++) begin
      r_load[d]   = -1;
      r_rvl[d]    = -1;
      r_add[d]    = 0;
      r_shift[d]  = 0;
      r_neg[d]    = -1;
      r_done[d]   = -1;
      r_ic[d]     = -1;
      r_busy10[d] = -1;
    end
  endtask

  task automatic op(input logic [W-1:0] b, input logic a_s,
                    input logic b_s);
    b_op = b;
    sa   = a_s;
    sb   = b_s;
    st   = 1'b1;
    t0   = cyc;
    clear_rec();
    tick();
    st = 1'b0;
  endtask

  initial begin
    bit idle;
    clear_rec();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    lit("reset_busy", int'(bus0.busy), 0);
    lit("reset_rv", int'(bus1.result_valid), 0);

    // 5 x 3
    op(8'd3, 1'b0, 1'b0);
    repeat (20) tick();
    lit("p_load0", r_load[0], 1);
    lit("p_add0", r_add[0], 32'h14);
    lit("p_shift0", r_shift[0], 8);
    lit("p_neg0", r_neg[0], -1);
    lit("p_done0", r_done[0], 18);
    lit("p_ic0", r_ic[0], 8);
    lit("p_done1", r_done[1], 7);
    lit("p_shift1", r_shift[1], 2);
    lit("p_add1", r_add[1], 32'h14);

    // back-to-back: -5 x 3 started in the DONE cycle
    op(8'd3, 1'b0, 1'b0);
    repeat (17) tick();
    lit("b2b_in_done", int'(bus0.done), 1);
    op(8'd3, 1'b1, 1'b0);
    repeat (22) tick();
    lit("b2b_load0", r_load[0], 1);
    lit("b2b_rvl0", r_rvl[0], 0);
    lit("n_neg0", r_neg[0], 18);
    lit("n_done0", r_done[0], 19);
    lit("n_neg1", r_neg[1], 7);
    lit("n_done1", r_done[1], 8);
    lit("n_ic1", r_ic[1], 2);

    // zero multiplier, both signs set
    op(8'd0, 1'b1, 1'b1);
    repeat (22) tick();
    lit("z_done1", r_done[1], 3);
    lit("z_shift1", r_shift[1], 0);
    lit("z_add1", r_add[1], 0);
    lit("z_neg1", r_neg[1], -1);
    lit("z_neg0", r_neg[0], -1);
    lit("z_done0", r_done[0], 18);

    // abort at cycle 9 with extra starts at 5 and 9
    op(8'h83, 1'b0, 1'b0);
    for (int r = 1; r < 30; r++) begin
      st = (r == 5) || (r == 9);
      ab = (r == 9);
      tick();
    end
    st = 1'b0;
    ab = 1'b0;
    lit("ab_done0", r_done[0], -1);
    lit("ab_done1", r_done[1], -1);
    lit("ab_busy10_0", r_busy10[0], 0);
    lit("ab_busy10_1", r_busy10[1], 0);
    lit("ab_rv0", int'(bus0.result_valid), 0);

    // reset held two cycles mid-SHIFT
    op(8'h83, 1'b1, 1'b0);
    for (int r = 1; r < 20; r++) begin
      rst = (r == 7) || (r == 8);
      tick();
    end
    rst = 1'b0;
    lit("rs_done0", r_done[0], -1);
    lit("rs_neg1", r_neg[1], -1);
    lit("rs_ic0", int'(bus0.iter_count), 0);
    lit("rs_busy1", int'(bus1.busy), 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      idle = (sch[0].size() == 0) && (sch[1].size() == 0);
      rst = ($urandom_range(199) == 0);
      ab  = ($urandom_range(39) == 0);
      st  = ($urandom_range(9) < 2);
      if (idle && st) begin
        case ($urandom_range(3))
          0:       b_op = '0;
          1:       b_op = W'($urandom_range(15));
          default: b_op = W'($urandom);
        endcase
        sa = 1'($urandom);
        sb = 1'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    st  = 1'b0;
    ab  = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Cycle-level sequencer for the shift-add signed multiplier datapath. It accepts a one-cycle start pulse from the button-driven control path and captures the operand signs. It then issues load / add / shift / negate strobes to the datapath registers, with optional early termination. It reports busy, a done pulse and a held result-valid flag to the display logic.

## Interface
Parameters:
- WIDTH, 8: operand magnitude width; number of add/shift iterations.
- EARLY_TERM, 1: 1 = finish as soon as the multiplier register is zero.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse (debounced button).
- abort  in  1  synchronous cancel of an operation in progress.
- sign_a  in  1  multiplicand sign; sampled with start.
- sign_b  in  1  multiplier sign; sampled with start.
- mplier_lsb  in  1  LSB of the datapath multiplier register.
- mplier_zero  in  1  datapath multiplier register == 0.
- load  out  1  load operand magnitudes; clear the product register.
- add_en  out  1  product += shifted multiplicand.
- shift_en  out  1  multiplicand <<1, multiplier >>1.
- negate  out  1  product <= two's complement of product.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result_valid  out  1  product register holds a finished result.
- iter_count  out  $clog2(WIDTH)+1  completed shift iterations.

## Operation
- States: IDLE, LOAD, TEST, SHIFT, NEG, DONE. All outputs are Moore-decoded from state and registers, except add_en.
- IDLE / DONE: busy=0. On start, go to LOAD and capture neg_r <= sign_a ^ sign_b. result_valid is 1 in DONE and stays set in IDLE until the next start clears it.
- LOAD: load=1, busy=1, iter_count <= 0. Next state is TEST.
- TEST: busy=1.
  - If EARLY_TERM && mplier_zero: go to NEG if neg_r, else DONE. No add_en.
  - Otherwise add_en = mplier_lsb (combinational, this cycle only). Next state is SHIFT.
- SHIFT: shift_en=1, busy=1, iter_count <= iter_count+1.
  - If iter_count == WIDTH-1, go to NEG if neg_r, else DONE.
  - Otherwise go to TEST.
- NEG: negate=1, busy=1. Next state is DONE.
- DONE: done=1 for exactly one cycle and result_valid <= 1. Next state is IDLE unless start is high, which goes to LOAD.
- start while busy: ignored; neg_r is not re-sampled.
- abort while busy: next state IDLE, result_valid stays 0, no done. abort outranks every other transition, including the final SHIFT→DONE. abort in IDLE/DONE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- At most one of load, add_en, shift_en, negate is high in any cycle.
- iter_count never exceeds WIDTH. It holds its value after completion until the next LOAD.

## Timing
- Reset (rst sampled high): state=IDLE, neg_r=0, iter_count=0, result_valid=0. All strobes, busy and done are 0 in the following cycle. Reset mid-operation has the same effect, with no done pulse.
- Let cycle 0 be the cycle where start is sampled high:
  - Cycle 1: LOAD. The datapath updates at the end of cycle 1.
  - Cycle 2: first TEST. mplier_lsb and mplier_zero reflect the loaded operand.
- Full run (no early termination): TEST/SHIFT pairs occupy cycles 2..2·WIDTH+1. NEG, if needed, is cycle 2·WIDTH+2. done is asserted in cycle 2·WIDTH+2 (positive result) or 2·WIDTH+3 (negative result). For WIDTH=8 that is cycle 18 or 19.
- Early termination happens in the first TEST that sees mplier_zero. done follows 1 cycle later (positive) or 2 cycles later (negative).
- The datapath must present mplier_lsb and mplier_zero registered, valid from the start of each TEST cycle.
- Back-to-back operation: start in the DONE cycle gives LOAD in the next cycle, with no IDLE gap.

## Test plan
- Reset: hold rst 2 cycles mid-SHIFT → state IDLE; busy, done, result_valid and iter_count all 0 on the next cycle; no strobes afterwards.
- 5×3 positive, EARLY_TERM=0, WIDTH=8: start at cycle 0; bench model drives multiplier 3 (lsb sequence 1,1,0,0,0,0,0,0).
  - load in cycle 1.
  - add_en in cycles 2 and 4 only.
  - shift_en in cycles 3,5,…,17.
  - no negate; done in cycle 18.
  - iter_count=8 at done.
- −5×3, EARLY_TERM=1: sign_a=1, sign_b=0; multiplier 3 becomes zero after 2 shifts.
  - TEST in cycle 6 sees mplier_zero.
  - negate in cycle 7, done in cycle 8.
  - iter_count=2.
- Zero multiplier, EARLY_TERM=1, signs 1/1: mplier_zero high in cycle 2 → no add_en or shift_en; done in cycle 3; negate never asserted.
- abort at cycle 9 of a full run, with start pulses also given at cycles 5 and 9 → cycle 10 is IDLE; no done; result_valid=0; the extra starts have no effect.
- Back-to-back: start again in the DONE cycle of the 5×3 run → load the next cycle; result_valid drops to 0 with that start.
